// File: rtl/axi4_w_fifo_drain.sv
// Drains the AXI4 write-data FIFO onto a W channel. WLAST is counted from queued AW lengths;
// any disagreement with the FIFO's own last bit is flagged.
module axi4_w_fifo_drain (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic [7:0]  cmd_len_i,
  output logic        cmd_ready_o,
  input  logic [36:0] fifo_data_i,
  input  logic        fifo_empty_i,
  output logic        fifo_pop_o,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  input  logic        axi_wready_i,
  output logic        err_last_o,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e      state_q, state_d;
  logic [7:0]  q_mem_q [4];
  logic [1:0]  q_wr_ptr_q, q_rd_ptr_q;
  logic [2:0]  q_count_q;
  logic        q_push, q_pop, q_full, q_empty;
  logic [8:0]  issue_cnt_q, issue_cnt_d;
  logic        wvalid_q, wlast_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        err_last_q, err_q;
  logic        pop, beat_done, cnt_last, last_mismatch;

  assign q_full      = (q_count_q == 3'd4);
  assign q_empty     = (q_count_q == 3'd0);
  assign cmd_ready_o = !q_full;
  assign q_push      = cmd_valid_i & !q_full;
  assign q_pop       = (state_q == StIdle) & !q_empty;

  assign cnt_last      = (issue_cnt_q == 9'd1);
  assign beat_done     = wvalid_q & axi_wready_i;
  assign pop           = (state_q == StBurst) & (issue_cnt_q != 9'd0) & !fifo_empty_i &
                         (!wvalid_q | axi_wready_i);
  assign last_mismatch = fifo_data_i[36] != cnt_last;

  // Command queue of AW lengths
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) q_mem_q[i] <= '0;
      q_wr_ptr_q <= '0;
      q_rd_ptr_q <= '0;
      q_count_q  <= '0;
    end else begin
      if (q_push) begin
        q_mem_q[q_wr_ptr_q] <= cmd_len_i;
        q_wr_ptr_q          <= q_wr_ptr_q + 2'd1;
      end
      if (q_pop) q_rd_ptr_q <= q_rd_ptr_q + 2'd1;
      unique case ({q_push, q_pop})
        2'b10:   q_count_q <= q_count_q + 3'd1;
        2'b01:   q_count_q <= q_count_q - 3'd1;
        default: q_count_q <= q_count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!q_empty) begin
          state_d     = StBurst;
          issue_cnt_d = {1'b0, q_mem_q[q_rd_ptr_q]} + 9'd1;
        end
      end
      StBurst: begin
        if (pop) issue_cnt_d = issue_cnt_q - 9'd1;
        if (beat_done && wlast_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Output stage: payload only changes on a pop, so it holds while stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      err_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (pop) begin
        wvalid_q <= 1'b1;
        wdata_q  <= fifo_data_i[31:0];
        wstrb_q  <= fifo_data_i[35:32];
        wlast_q  <= cnt_last;
      end else if (beat_done) begin
        wvalid_q <= 1'b0;
      end
      err_last_q <= pop & last_mismatch;
      err_q      <= err_q | (pop & last_mismatch);
    end
  end

  assign fifo_pop_o   = pop;
  assign axi_wvalid_o = wvalid_q;
  assign axi_wdata_o  = wdata_q;
  assign axi_wstrb_o  = wstrb_q;
  assign axi_wlast_o  = wlast_q;
  assign err_last_o   = err_last_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q == StBurst) | wvalid_q;

endmodule

// File: tb/tb_axi4_w_fifo_drain.sv
// Directed bench for axi4_w_fifo_drain: FIFO model plus a beat scoreboard checked by a monitor.
module tb_axi4_w_fifo_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_len;
  logic        cmd_ready;
  logic [36:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wready;
  logic        err_last;
  logic        err;
  logic        busy;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    logic        e;
  } beat_t;

  logic [36:0] fifo_q [$];
  beat_t       exp_q  [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          pops  = 0;

  axi4_w_fifo_drain dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_len_i    (cmd_len),
    .cmd_ready_o  (cmd_ready),
    .fifo_data_i  (fifo_data),
    .fifo_empty_i (fifo_empty),
    .fifo_pop_o   (fifo_pop),
    .axi_wvalid_o (wvalid),
    .axi_wdata_o  (wdata),
    .axi_wstrb_o  (wstrb),
    .axi_wlast_o  (wlast),
    .axi_wready_i (wready),
    .err_last_o   (err_last),
    .err_o        (err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 37'd0 : fifo_q[0];
  endfunction

  // fifo_last is the FIFO's bit; cnt_last is the hand-computed counted WLAST
  task automatic push_word(input logic fifo_last, input logic [3:0] s, input logic [31:0] d,
                           input logic cnt_last);
    beat_t b;
    b.d = d;
    b.s = s;
    b.l = cnt_last;
    b.e = (fifo_last != cnt_last);
    fifo_q.push_back({fifo_last, s, d});
    exp_q.push_back(b);
    drive_fifo();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] len);
    int n;
    cmd_valid = 1'b1;
    cmd_len   = len;
    n = 0;
    while (!cmd_ready && n < 50) begin
      cyc();
      n++;
    end
    chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 600) begin
      cyc();
      n++;
    end
    chk(name, {62'd0, busy, 1'b0} | 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_wvalid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wvalid && n < 20);
    chk("wvalid_timeout", 64'(wvalid), 64'd1);
  endtask

  // FIFO model: consume the head on each pop the DUT commits to
  initial begin
    logic do_pop;
    forever begin
      @(negedge clk);
      do_pop = fifo_pop && !rst;
      @(posedge clk);
      #1;
      if (do_pop) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        pops++;
        drive_fifo();
      end
    end
  end

  // Monitor: scoreboard compare on each accepted beat, plus stability and err pulse checks
  initial begin
    logic        fresh, stall;
    logic [36:0] prev;
    beat_t       e;
    fresh = 1'b0;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fresh = 1'b0;
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", 64'(wvalid), 64'd1);
          chk("hold_payload", 64'({wdata, wstrb, wlast}), 64'(prev));
        end
        if (wvalid && fresh) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
          else chk("err_last_pulse", 64'(err_last), 64'(exp_q[0].e));
        end else begin
          chk("err_last_idle", 64'(err_last), 64'd0);
        end
        if (wvalid && wready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(wdata), 64'(e.d));
            chk("beat_strb", 64'(wstrb), 64'(e.s));
            chk("beat_last", 64'(wlast), 64'(e.l));
          end
        end
        stall = wvalid && !wready;
        prev  = {wdata, wstrb, wlast};
        fresh = fifo_pop;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string name);
    chk(name, 64'({cmd_ready, fifo_pop, wvalid, wdata, wstrb, wlast, err_last, err, busy}),
        64'({1'b1, 42'd0}));
  endtask

  initial begin
    int p0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    wready    = 1'b1;
    drive_fifo();
    #2;
    chk_reset_outputs("reset_values");
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Single beat: wvalid first seen three cycles after the command edge
    p0 = pops;
    push_word(1'b1, 4'hF, 32'hDEADBEEF, 1'b1);
    send_cmd(8'd0);
    @(negedge clk);
    chk("single_c1_wvalid", 64'(wvalid), 64'd0);
    cyc();
    @(negedge clk);
    chk("single_c2_wvalid", 64'(wvalid), 64'd0);
    cyc();
    @(negedge clk);
    chk("single_c3_wvalid", 64'(wvalid), 64'd1);
    wait_drain("single_drain");
    chk("single_pops", 64'(pops - p0), 64'd1);
    chk("single_err", 64'(err), 64'd0);

    // Four-beat stream: pops in cycles 2..5
    p0 = pops;
    for (int i = 0; i < 4; i++) push_word(i == 3, 4'hF, 32'(i), i == 3);
    send_cmd(8'd3);
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_pop_consec", 64'(fifo_pop), 64'd1);
      cyc();
    end
    wait_drain("stream_drain");
    chk("stream_pops", 64'(pops - p0), 64'd4);
    chk("stream_busy", 64'(busy), 64'd0);

    // Backpressure on beat 1
    wready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(i == 3, 4'hF, 32'(i), i == 3);
    send_cmd(8'd3);
    wait_wvalid();
    cyc();
    wready = 1'b1;
    cyc();
    wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_pop", 64'(fifo_pop), 64'd0);
      chk("stall_wdata", 64'(wdata), 64'd1);
      cyc();
    end
    wready = 1'b1;
    wait_drain("stall_drain");

    // Counted last vs FIFO last: first word carries a stray last bit
    chk("err_before_mismatch", 64'(err), 64'd0);
    push_word(1'b1, 4'hF, 32'hA0, 1'b0);
    push_word(1'b1, 4'h3, 32'hA1, 1'b1);
    send_cmd(8'd1);
    wait_drain("mismatch_drain");
    chk("err_sticky", 64'(err), 64'd1);

    // 256-beat burst: counter must not wrap
    for (int i = 0; i < 256; i++) push_word(i == 255, 4'h5, 32'h1000 + 32'(i), i == 255);
    send_cmd(8'd255);
    wait_drain("long_drain");

    // Async reset mid-burst with a stalled beat on the bus
    wready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(i == 3, 4'hF, 32'hB0 + 32'(i), i == 3);
    send_cmd(8'd3);
    wait_wvalid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_async");
    fifo_q.delete();
    exp_q.delete();
    drive_fifo();
    cyc();
    cyc();
    chk_reset_outputs("reset_held");
    rst    = 1'b0;
    wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 64'({wvalid, cmd_ready, busy}), 64'b010);
      cyc();
    end

    // Queue full: five accepted with the FIFO empty, sixth waits for a drain
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("qfull_ready", 64'(cmd_ready), 64'(i < 5));
      cyc();
    end
    push_word(1'b1, 4'hF, 32'hC0, 1'b1);
    begin
      int n;
      n = 0;
      while (!cmd_ready && n < 20) begin
        cyc();
        n++;
      end
      chk("qfull_sixth_accept", 64'(cmd_ready), 64'd1);
    end
    cyc();
    cmd_valid = 1'b0;
    for (int i = 1; i < 6; i++) push_word(1'b1, 4'hF, 32'hC0 + 32'(i), 1'b1);
    wait_drain("qfull_drain");
    cyc();
    chk("qfull_idle_ready", 64'(cmd_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_w_fifo_drain.md
# axi4_w_fifo_drain

Single-clock drain engine that sits on the read side of the 37-bit AXI4 write-data FIFO and replays its contents as an AXI4 W channel. It pops FIFO words ({last, strb[3:0], data[31:0]}) and presents them through a registered valid/ready output stage. Burst boundaries come from queued AW lengths, so WLAST is generated by count and not by the FIFO's last bit. Any disagreement between the counted last and the FIFO last bit is flagged.

## Interface
- No parameters. The command queue depth is fixed at 4. Data is fixed at 32 bits with a 4-bit strobe.
- clk_i  input  1  the single clock.
- rst_i  input  1  asynchronous, active-high reset.
- cmd_valid_i  input  1  burst command present.
- cmd_len_i  input  8  AXI awlen: beats minus 1.
- cmd_ready_o  output  1  command queue not full.
- fifo_data_i  input  37  FIFO head word: [31:0] data, [35:32] strb, [36] last.
- fifo_empty_i  input  1  FIFO empty. fifo_data_i is valid whenever this is low.
- fifo_pop_o  output  1  consume the head word this cycle.
- axi_wvalid_o  output  1  W beat valid.
- axi_wdata_o  output  32  W data.
- axi_wstrb_o  output  4  W strobe.
- axi_wlast_o  output  1  counted last beat of the burst.
- axi_wready_i  input  1  W ready.
- err_last_o  output  1  one-cycle pulse, aligned with the first cycle the mismatching beat is presented.
- err_o  output  1  sticky mismatch flag. Cleared only by rst_i.
- busy_o  output  1  high when the block is in BURST or axi_wvalid_o is high.

## Operation
- **Command queue**
  - 4-entry FIFO of cmd_len_i.
  - cmd_ready_o = queue not full. A full queue gives no same-cycle pass-through, even if an entry is being removed that cycle.
  - Push on cmd_valid_i & cmd_ready_o.
- **FSM states: IDLE, BURST.**
  - IDLE: if the queue is non-empty, remove the head, load issue_cnt = len+1 (9 bits, range 1..256), and go to BURST.
  - BURST: stays until the beat with axi_wlast_o=1 is accepted (wvalid & wready & wlast), then returns to IDLE.
- **Pop rule**
  - fifo_pop_o = (state==BURST) & (issue_cnt!=0) & !fifo_empty_i & (!axi_wvalid_o | axi_wready_i). This is combinational.
  - On a pop, the output register loads data and strb from fifo_data_i, sets wlast = (issue_cnt==1) and wvalid = 1, and decrements issue_cnt.
- **Output register**
  - If the current beat is accepted and there is no pop, wvalid clears.
  - Data, strb and wlast are held stable while wvalid & !wready (AXI stability rule).
- **Last check**
  - On each pop, if fifo_data_i[36] != (issue_cnt==1), err_last_o is registered high for exactly one cycle and err_o is set.
  - The counted wlast is always what drives axi_wlast_o. The FIFO bit is never forwarded.
- **Reset values (also apply on reset mid-burst)**
  - Async reset clears the FSM to IDLE, empties the queue, sets issue_cnt=0, and clears the output register and errors. In-flight beats are dropped.
  - Output values during and after reset: cmd_ready_o=1, fifo_pop_o=0, axi_wvalid_o=0, axi_wdata_o=0, axi_wstrb_o=0, axi_wlast_o=0, err_last_o=0, err_o=0, busy_o=0.
- **Boundary conditions**
  - len=255 gives 256 beats. The 9-bit counter must not wrap.
  - FIFO empty mid-burst: no pop. wvalid drops once the held beat is accepted, and the burst resumes when data arrives.
  - Queue pointers wrap modulo 4. Simultaneous push and pop on a partly full queue is legal.

## Timing
- **First beat of a burst**
  - Command accepted in cycle 0.
  - Queue non-empty in cycle 1; IDLE loads the command.
  - BURST in cycle 2; first pop in cycle 2 if the FIFO is not empty.
  - axi_wvalid_o high in cycle 3.
- **Throughput:** 1 beat per cycle while axi_wready_i=1 and the FIFO is non-empty.
- **Burst-to-burst gap**
  - Last beat accepted in cycle k; IDLE in cycle k+1; BURST in cycle k+2.
  - Next axi_wvalid_o at k+3 at the earliest, giving 2 idle W cycles.
- **Capacity:** with the FIFO empty, 5 commands are accepted before cmd_ready_o falls (1 active plus 4 queued).

## Test plan
- **Reset:** assert rst_i asynchronously mid-burst with wvalid high -> all outputs take their reset values immediately; after release, no stale beat appears and cmd_ready_o=1.
- **Single beat:** cmd len=0; FIFO word {1,4'hF,32'hDEADBEEF}; wready=1 -> wvalid in cycle 3 with wdata=DEADBEEF, wstrb=F, wlast=1; exactly one pop; err_o stays 0.
- **Four-beat streaming:** len=3; FIFO words data 0..3 with last set on data 3; wready=1 -> 4 consecutive beats; wlast only on data 3; fifo_pop_o high for 4 consecutive cycles; busy_o falls after the last beat.
- **Backpressure:** len=3; wready held low for 3 cycles while beat 1 is presented -> wdata=1 held stable, fifo_pop_o=0 during the stall, no beat lost or duplicated.
- **Last mismatch:** len=1; FIFO last bit=1 on the first word -> err_last_o pulses for 1 cycle with beat 0; axi_wlast_o is asserted on beat 1 only; err_o stays set.
- **Queue full:** FIFO empty; 6 commands offered back-to-back -> the first 5 are accepted and cmd_ready_o=0 from the 6th cycle; after FIFO data drains the first burst, the 6th command is accepted.
